axis_blk_proc: RTL and testbench
================================

Name: axis_blk_proc

Overview:
- Parametrised AXI4-Stream front end for the miner core: deserialises IN_WORDS beats into one wide block, pulses the core start, waits for done, then serialises the OUT_WORDS result back out.
- Sits between the input AXIS VIP/DMA slave port and the output AXIS master port in design_1.
- Successor to the fixed 32-bit single-channel wrapper, adding:
  - configurable word width and word counts;
  - tlast framing checks;
  - a sticky error flag;
  - back-to-back frame handling.

Parameters:
- DATA_WIDTH, 32, AXIS tdata width in bits (multiple of 8).
- IN_WORDS, 20, beats per input frame (block header words).
- OUT_WORDS, 2, beats per output frame (result words).
- TIMEOUT_CYCLES, 2**24, core watchdog limit (used only with the optional feature).

Ports:
- aclk in 1 system clock
- aresetn in 1 asynchronous active-low reset
- s_axis_tdata in DATA_WIDTH input word
- s_axis_tvalid in 1 input valid
- s_axis_tready out 1 input ready
- s_axis_tlast in 1 input end of frame
- m_axis_tdata out DATA_WIDTH output word
- m_axis_tvalid out 1 output valid
- m_axis_tready in 1 output ready
- m_axis_tlast out 1 output end of frame
- core_blk out IN_WORDS*DATA_WIDTH assembled block; word 0 in the MS slice
- core_start out 1 one-cycle start pulse
- core_done in 1 core completion, level or pulse, sampled in WAIT
- core_result in OUT_WORDS*DATA_WIDTH core result; MS slice is sent first
- err out 1 sticky framing/timeout error
- busy out 1 high in any state other than RECV

Behaviour:
- Reset (aresetn low, asynchronous):
  - state=RECV, word counter=0;
  - s_axis_tready=0 for the first cycle after deassertion, then 1;
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, core_start=0, core_blk=0, err=0, busy=0.
- Reset mid-frame or mid-core discards all progress; a partial frame is never forwarded.
- FSM states: RECV -> START -> WAIT -> SEND -> RECV.
- RECV:
  - s_axis_tready=1.
  - On each beat (tvalid&tready): store tdata into slice cnt of core_blk, cnt++.
  - Beat with cnt==IN_WORDS-1 and tlast=1: go to START, cnt=0.
  - Beat with tlast=1 and cnt<IN_WORDS-1 (early tlast): frame dropped, cnt=0, err=1, stay in RECV.
  - Beat with cnt==IN_WORDS-1 and tlast=0 (missing tlast): err=1, frame still accepted, go to START; subsequent beats up to and including the next tlast are discarded before new framing starts.
- START:
  - s_axis_tready=0, core_start=1 for exactly one cycle, core_blk held stable.
  - Next state WAIT.
- WAIT:
  - Hold until core_done=1 is sampled.
  - Then latch core_result into the output shift register and go to SEND.
  - A core_done already high in the START cycle is ignored; it is sampled only from the first WAIT cycle.
- SEND:
  - m_axis_tvalid=1, m_axis_tdata=current MS slice.
  - m_axis_tlast=1 only on beat OUT_WORDS-1.
  - tvalid and tdata stay stable while tready=0 (AXIS rule; no combinational path from tready to tvalid).
  - On handshake: shift, counter++.
  - After the last handshake: tvalid=0 next cycle and go to RECV.
- Latency:
  - Last input beat to core_start: 1 cycle.
  - core_done sampled to first m_axis_tvalid: 1 cycle.
  - Last output handshake to s_axis_tready=1: 1 cycle.
- Input is not accepted during START/WAIT/SEND (tready=0); upstream back-pressures.
- err clears only on reset.
- Width rules: counters sized $clog2(max(IN_WORDS,OUT_WORDS))+1. IN_WORDS=1 and OUT_WORDS=1 are legal: tlast is required on every beat and output tlast is always 1.

Optional Feature:
- Macro AXIS_BLK_PROC_TIMEOUT_EN.
- Defined:
  - 32-bit watchdog cleared on START, incremented each WAIT cycle.
  - Reaching TIMEOUT_CYCLES before core_done: err=1, output frame is OUT_WORDS beats of all-ones, then RECV.
  - core_done in the same cycle as the timeout wins (normal result sent).
- Undefined: no counter, WAIT lasts indefinitely, TIMEOUT_CYCLES is ignored.

Test Plan:
- Test 1: 20 beats 0x00000001..0x00000014, tlast on beat 20, tready always 1, core_done 5 cycles after start with result {0xDEADBEEF,0x00000001} -> core_blk MS word=0x00000001, LS word=0x00000014; one core_start pulse; output 0xDEADBEEF then 0x00000001 with tlast on the second; err=0.
- Test 2: tlast on beat 7 -> no core_start, err=1; a following correct 20-beat frame is processed normally.
- Test 3: m_axis_tready oscillating 2 low / 6 high -> output data held stable across stalls; exactly 2 beats in order.
- Test 4: two frames back-to-back with tvalid constantly high -> second frame stalls (tready=0) until first output completes, then processes; 4 output beats total.
- Test 5: aresetn asserted at beat 10 of a frame -> all outputs at reset values; next full frame produces correct result and no err.
- Test 6 (AXIS_BLK_PROC_TIMEOUT_EN, TIMEOUT_CYCLES=100): core_done never asserted -> err=1 at cycle 100 of WAIT; output 0xFFFFFFFF, 0xFFFFFFFF with tlast on the second.

Source files
------------

// File: rtl/axis_blk_proc_if.sv
// axis_blk_proc_if: AXI4-Stream beat bundle (tdata/tvalid/tready/tlast).
// master drives data/valid/last and sees ready; slave is the reverse.
interface axis_blk_proc_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_blk_proc.sv
// axis_blk_proc: AXIS front end for the miner core. Collects IN_WORDS beats
// into core_blk (word 0 in MS slice), pulses core_start, waits for
// core_done, then streams OUT_WORDS result words (MS slice first).
// Ports: aclk, aresetn (async active-low); s_axis (slave AXIS in);
//   m_axis (master AXIS out); core_blk/core_start to core;
//   core_done/core_result from core; err (sticky framing/timeout);
//   busy (state other than RECV).
// Option: define AXIS_BLK_PROC_TIMEOUT_EN for the core watchdog.
module axis_blk_proc #(
  parameter int DATA_WIDTH     = 32,
  parameter int IN_WORDS       = 20,
  parameter int OUT_WORDS      = 2,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  axis_blk_proc_if.slave                  s_axis,
  axis_blk_proc_if.master                 m_axis,
  output logic [IN_WORDS*DATA_WIDTH-1:0]  core_blk,
  output logic                            core_start,
  input  logic                            core_done,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0] core_result,
  output logic                            err,
  output logic                            busy
);

  localparam int MAXW = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam int BW   = IN_WORDS * DATA_WIDTH;
  localparam int OW   = OUT_WORDS * DATA_WIDTH;

  localparam logic [CW-1:0] LAST_IN  = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(OUT_WORDS - 1);

  typedef enum logic [1:0] {
    S_RECV,
    S_START,
    S_WAIT,
    S_SEND
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [OW-1:0]   out_q, out_d;
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic            rdy_q;
  logic            beat;

`ifdef AXIS_BLK_PROC_TIMEOUT_EN
  logic [31:0]     wdog_q, wdog_d;
`else
  logic [31:0]     unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Ready stays low for the first cycle out of reset.
  assign s_axis.tready = (state_q == S_RECV) & rdy_q;
  assign beat          = s_axis.tvalid & s_axis.tready;

  assign m_axis.tvalid = (state_q == S_SEND);
  assign m_axis.tlast  = (state_q == S_SEND) && (cnt_q == LAST_OUT);
  assign m_axis.tdata  = out_q[OW-1 -: DATA_WIDTH];

  assign core_blk   = blk_q;
  assign core_start = (state_q == S_START);
  assign err        = err_q;
  assign busy       = (state_q != S_RECV);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_RECV;
      cnt_q   <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      rdy_q   <= 1'b1;
    end
  end

`ifdef AXIS_BLK_PROC_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    out_d   = out_q;
    err_d   = err_q;
    drop_d  = drop_q;
`ifdef AXIS_BLK_PROC_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      S_RECV: begin
        if (beat) begin
          if (drop_q) begin
            // Flush the tail of an over-long frame through its tlast.
            if (s_axis.tlast) drop_d = 1'b0;
          end else begin
            for (int i = 0; i < IN_WORDS; i++) begin
              if (cnt_q == CW'(IN_WORDS - 1 - i))
                blk_d[i*DATA_WIDTH +: DATA_WIDTH] = s_axis.tdata;
            end
            if (cnt_q == LAST_IN) begin
              cnt_d   = '0;
              state_d = S_START;
              if (!s_axis.tlast) begin
                err_d  = 1'b1;
                drop_d = 1'b1;
              end
            end else if (s_axis.tlast) begin
              cnt_d = '0;
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef AXIS_BLK_PROC_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (core_done) begin
          out_d   = core_result;
          cnt_d   = '0;
          state_d = S_SEND;
        end
`ifdef AXIS_BLK_PROC_TIMEOUT_EN
        else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
          out_d   = '1;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          wdog_d  = wdog_q + 32'd1;
        end
`endif
      end
      S_SEND: begin
        if (m_axis.tready) begin
          out_d = out_q << DATA_WIDTH;
          if (cnt_q == LAST_OUT) begin
            cnt_d   = '0;
            state_d = S_RECV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_RECV;
    endcase
  end

endmodule

// File: tb/tb_axis_blk_proc.sv
// tb_axis_blk_proc: directed bench for axis_blk_proc.
// Core model answers each core_start from a queue of results.
module tb_axis_blk_proc;

  localparam int DW  = 32;
  localparam int IW  = 20;
  localparam int OWN = 2;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axis_blk_proc_if #(.DATA_WIDTH(DW)) s_if ();
  axis_blk_proc_if #(.DATA_WIDTH(DW)) m_if ();

  logic [IW*DW-1:0]  core_blk;
  logic              core_start;
  logic              core_done = 1'b0;
  logic [OWN*DW-1:0] core_result = '0;
  logic              err;
  logic              busy;

  axis_blk_proc #(
    .DATA_WIDTH    (DW),
    .IN_WORDS      (IW),
    .OUT_WORDS     (OWN),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .core_blk   (core_blk),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .err        (err),
    .busy       (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int  starts     = 0;
  int  cd         = 0;
  int  cyc        = 0;
  int  st_cyc     = 0;
  int  v_cyc      = 0;
  int  core_delay = 5;
  bit  core_en    = 1'b1;
  bit  mode       = 1'b0;
  int  ph         = 0;
  bit  v_prev     = 1'b0;
  bit  stall_prev = 1'b0;
  int  stalls     = 0;
  logic [31:0] stall_d = '0;

  logic [63:0] res_q[$];
  logic [31:0] got_d[$];
  logic        got_l[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core responder, output sink and stall checker, all at +1 after edge.
  always begin
    @(posedge aclk);
    #1;
    cyc++;
    core_done = 1'b0;
    if (!aresetn) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0 && core_en) core_done = 1'b1;
      end
      if (core_start) begin
        starts++;
        st_cyc = cyc;
        cd     = core_delay;
        if (res_q.size() > 0) core_result = res_q.pop_front();
      end
    end
    if (stall_prev) begin
      chk("stall_valid", 64'(m_if.tvalid), 64'd1);
      chk("stall_data", 64'(m_if.tdata), 64'(stall_d));
    end
    if (m_if.tvalid && !v_prev) begin
      v_cyc = cyc;
      ph    = 0;
    end
    v_prev      = m_if.tvalid;
    m_if.tready = mode ? ((ph % 8) >= 2) : 1'b1;
    ph++;
    stall_prev = m_if.tvalid && !m_if.tready;
    if (stall_prev) begin
      stall_d = m_if.tdata;
      stalls++;
    end
    if (m_if.tvalid && m_if.tready) begin
      got_d.push_back(m_if.tdata);
      got_l.push_back(m_if.tlast);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic put(input logic [31:0] d, input logic l, output int waited);
    int n = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && n < 300) begin
      tick();
      n++;
    end
    waited = n;
    if (n >= 300) chk("put_timeout", 64'(n), 64'd0);
    tick();
  endtask

  task automatic send_frame(input logic [31:0] base, input int n,
                            input int lastpos, input bit keep,
                            output int w0);
    int w;
    w0 = 0;
    for (int i = 0; i < n; i++) begin
      put(base + 32'(i), (i + 1) == lastpos, w);
      if (i == 0) w0 = w;
    end
    if (!keep) begin
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (got_d.size() < n && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) chk("out_timeout", 64'(got_d.size()), 64'(n));
  endtask

  task automatic chk_beat(input string tag, input int i,
                          input logic [31:0] d, input logic l);
    chk({tag, "_data"}, 64'(got_d[i]), 64'(d));
    chk({tag, "_last"}, 64'(got_l[i]), 64'(l));
  endtask

  task automatic clr_out();
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    int w;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) tick();

    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_blk", 64'(|core_blk), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("rel_tready_first", 64'(s_if.tready), 64'd0);
    tick();
    chk("rel_tready_then", 64'(s_if.tready), 64'd1);

    // Test 1: nominal frame
    starts = 0;
    clr_out();
    res_q.push_back({32'hDEADBEEF, 32'h00000001});
    send_frame(32'h1, 20, 20, 1'b0, w);
    chk("t1_start", 64'(core_start), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_tready", 64'(s_if.tready), 64'd0);
    chk("t1_blk_ms", 64'(core_blk[IW*DW-1 -: DW]), 64'h1);
    chk("t1_blk_w9", 64'(core_blk[(IW-10)*DW +: DW]), 64'hA);
    chk("t1_blk_ls", 64'(core_blk[DW-1:0]), 64'h14);
    wait_out(2);
    chk_beat("t1_b0", 0, 32'hDEADBEEF, 1'b0);
    chk_beat("t1_b1", 1, 32'h00000001, 1'b1);
    chk("t1_lat", 64'(v_cyc - st_cyc), 64'd6);
    tick();
    chk("t1_tready_back", 64'(s_if.tready), 64'd1);
    chk("t1_tvalid_low", 64'(m_if.tvalid), 64'd0);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_starts", 64'(starts), 64'd1);
    chk("t1_err", 64'(err), 64'd0);

    // Test 2: early tlast then good frame
    starts = 0;
    clr_out();
    send_frame(32'h50, 7, 7, 1'b0, w);
    chk("t2_err", 64'(err), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_tready", 64'(s_if.tready), 64'd1);
    repeat (8) tick();
    chk("t2_no_start", 64'(starts), 64'd0);
    res_q.push_back({32'h12345678, 32'h9ABCDEF0});
    send_frame(32'h100, 20, 20, 1'b0, w);
    chk("t2_blk_ms", 64'(core_blk[IW*DW-1 -: DW]), 64'h100);
    chk("t2_blk_ls", 64'(core_blk[DW-1:0]), 64'h113);
    wait_out(2);
    chk_beat("t2_b0", 0, 32'h12345678, 1'b0);
    chk_beat("t2_b1", 1, 32'h9ABCDEF0, 1'b1);
    tick();
    chk("t2_starts", 64'(starts), 64'd1);
    chk("t2_err_sticky", 64'(err), 64'd1);

    // Test 3: output back-pressure 2 low / 6 high
    mode   = 1'b1;
    stalls = 0;
    clr_out();
    res_q.push_back({32'hCAFEF00D, 32'h0BADC0DE});
    send_frame(32'h200, 20, 20, 1'b0, w);
    wait_out(2);
    chk_beat("t3_b0", 0, 32'hCAFEF00D, 1'b0);
    chk_beat("t3_b1", 1, 32'h0BADC0DE, 1'b1);
    repeat (6) tick();
    chk("t3_count", 64'(got_d.size()), 64'd2);
    chk("t3_stalls", 64'(stalls), 64'd2);
    mode = 1'b0;
    tick();

    // Test 4: back-to-back frames, tvalid held high
    starts = 0;
    clr_out();
    res_q.push_back({32'h11111111, 32'h22222222});
    res_q.push_back({32'h33333333, 32'h44444444});
    send_frame(32'h300, 20, 20, 1'b1, w);
    send_frame(32'h400, 20, 20, 1'b0, w);
    chk("t4_b_wait", 64'(w), 64'd8);
    chk("t4_blk_ms", 64'(core_blk[IW*DW-1 -: DW]), 64'h400);
    wait_out(4);
    chk_beat("t4_b0", 0, 32'h11111111, 1'b0);
    chk_beat("t4_b1", 1, 32'h22222222, 1'b1);
    chk_beat("t4_b2", 2, 32'h33333333, 1'b0);
    chk_beat("t4_b3", 3, 32'h44444444, 1'b1);
    tick();
    chk("t4_starts", 64'(starts), 64'd2);

    // Test 5: reset in mid-frame
    starts = 0;
    clr_out();
    send_frame(32'h500, 10, 0, 1'b1, w);
    aresetn = 1'b0;
    #1;
    chk("t5_s_tready", 64'(s_if.tready), 64'd0);
    chk("t5_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t5_m_tdata", 64'(m_if.tdata), 64'd0);
    chk("t5_blk", 64'(|core_blk), 64'd0);
    chk("t5_err", 64'(err), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    s_if.tvalid = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    res_q.push_back({32'hFEEDFACE, 32'h00C0FFEE});
    send_frame(32'h600, 20, 20, 1'b0, w);
    chk("t5_blk_ms", 64'(core_blk[IW*DW-1 -: DW]), 64'h600);
    chk("t5_blk_ls", 64'(core_blk[DW-1:0]), 64'h613);
    wait_out(2);
    chk_beat("t5_b0", 0, 32'hFEEDFACE, 1'b0);
    chk_beat("t5_b1", 1, 32'h00C0FFEE, 1'b1);
    tick();
    chk("t5_err_clear", 64'(err), 64'd0);
    chk("t5_starts", 64'(starts), 64'd1);

`ifdef AXIS_BLK_PROC_TIMEOUT_EN
    // Test 6: core never answers
    core_en = 1'b0;
    clr_out();
    send_frame(32'h700, 20, 20, 1'b0, w);
    repeat (50) tick();
    chk("t6_err_early", 64'(err), 64'd0);
    wait_out(2);
    chk_beat("t6_b0", 0, 32'hFFFFFFFF, 1'b0);
    chk_beat("t6_b1", 1, 32'hFFFFFFFF, 1'b1);
    chk("t6_lat", 64'(v_cyc - st_cyc), 64'd101);
    chk("t6_err", 64'(err), 64'd1);
    tick();
    core_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
